// File: rtl/controller_pkg.sv
// -----------------------------------------------------------------------------
// controller_pkg
// Shared encodings for the single-cycle MIPS-subset control unit: opcode and
// funct constants, the 4-bit ALU operation enum, the internal ALU-op class
// enum, and the main-decoder control bundle with a small constructor.
// -----------------------------------------------------------------------------
package controller_pkg;

    localparam int OP_W    = 6;
    localparam int FUNCT_W = 6;
    localparam int ALU_W   = 4;

    // Opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (instruction[5:0])
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_NOR = 6'b100111;
    localparam logic [5:0] F_SLT = 6'b101010;

    // ALU operation seen by the datapath
    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alucontrol_t;

    // Operation class handed from the main decoder to the ALU decoder
    typedef enum logic [2:0] {
        ALUOP_ADD   = 3'd0,
        ALUOP_SUB   = 3'd1,
        ALUOP_FUNCT = 3'd2,
        ALUOP_AND   = 3'd3,
        ALUOP_OR    = 3'd4,
        ALUOP_SLT   = 3'd5
    } aluop_t;

    // Opcode-level control bundle
    typedef struct packed {
        logic   regwrite;
        logic   regdst;
        logic   alusrc;
        logic   memwrite;
        logic   memtoreg;
        logic   jump;
        logic   branch_eq;
        logic   branch_ne;
        aluop_t aluop;
    } main_ctrl_t;

    // Builds one row of the main decode table
    function automatic main_ctrl_t main_ctrl(
        input logic   regwrite,
        input logic   regdst,
        input logic   alusrc,
        input logic   memwrite,
        input logic   memtoreg,
        input logic   jump,
        input logic   branch_eq,
        input logic   branch_ne,
        input aluop_t aluop
    );
        main_ctrl_t c;
        c.regwrite  = regwrite;
        c.regdst    = regdst;
        c.alusrc    = alusrc;
        c.memwrite  = memwrite;
        c.memtoreg  = memtoreg;
        c.jump      = jump;
        c.branch_eq = branch_eq;
        c.branch_ne = branch_ne;
        c.aluop     = aluop;
        return c;
    endfunction

    // Side-effect-free control word used for unknown opcodes
    localparam main_ctrl_t MAIN_CTRL_NOP = '{
        regwrite:  1'b0,
        regdst:    1'b0,
        alusrc:    1'b0,
        memwrite:  1'b0,
        memtoreg:  1'b0,
        jump:      1'b0,
        branch_eq: 1'b0,
        branch_ne: 1'b0,
        aluop:     ALUOP_ADD
    };

endpackage

// File: rtl/controller_if.sv
// -----------------------------------------------------------------------------
// controller_if
// Instruction-field inputs and datapath control outputs of the control unit.
//   op, funct, zero       : driven by the datapath (master), read by controller
//   memtoreg .. alucontrol : driven by the controller (slave), read by datapath
// -----------------------------------------------------------------------------
interface controller_if;
    import controller_pkg::*;

    logic [OP_W-1:0]    op;
    logic [FUNCT_W-1:0] funct;
    logic               zero;
    logic               memtoreg;
    logic               memwrite;
    logic               pcsrc;
    logic               alusrc;
    logic               regdst;
    logic               regwrite;
    logic               jump;
    logic [ALU_W-1:0]   alucontrol;

    modport master (
        output op, funct, zero,
        input  memtoreg, memwrite, pcsrc, alusrc, regdst, regwrite, jump, alucontrol
    );

    modport slave (
        input  op, funct, zero,
        output memtoreg, memwrite, pcsrc, alusrc, regdst, regwrite, jump, alucontrol
    );

endinterface

// File: rtl/controller_aludec.sv
// -----------------------------------------------------------------------------
// controller_aludec
// ALU operation decoder.
//   aluop       : operation class from the main decoder
//   funct       : instruction[5:0], only examined when aluop is FUNCT
//   alucontrol  : 4-bit ALU operation
//   funct_valid : low when an R-type funct lies outside the supported set
// -----------------------------------------------------------------------------
module controller_aludec
    import controller_pkg::*;
(
    input  aluop_t             aluop,
    input  logic [FUNCT_W-1:0] funct,
    output alucontrol_t        alucontrol,
    output logic               funct_valid
);

    // Class-to-operation mapping; funct is looked at only inside the FUNCT arm
    // so an undefined funct field on I/J instructions cannot reach the outputs
    always_comb begin
        alucontrol  = ALU_ADD;
        funct_valid = 1'b1;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_AND: alucontrol = ALU_AND;
            ALUOP_OR:  alucontrol = ALU_OR;
            ALUOP_SLT: alucontrol = ALU_SLT;
            ALUOP_FUNCT: begin
                case (funct)
                    F_ADD:   alucontrol = ALU_ADD;
                    F_SUB:   alucontrol = ALU_SUB;
                    F_AND:   alucontrol = ALU_AND;
                    F_OR:    alucontrol = ALU_OR;
                    F_NOR:   alucontrol = ALU_NOR;
                    F_SLT:   alucontrol = ALU_SLT;
                    default: begin
                        alucontrol  = ALU_ADD;
                        funct_valid = 1'b0;
                    end
                endcase
            end
            default: begin
                alucontrol  = ALU_ADD;
                funct_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/controller_maindec.sv
// -----------------------------------------------------------------------------
// controller_maindec
// Opcode decoder. Produces the opcode-level control bundle.
//   op   : instruction[31:26]
//   ctrl : register/memory/jump controls, branch kind, ALU-op class
// funct is deliberately not an input, so it cannot affect non-R decoding.
// -----------------------------------------------------------------------------
module controller_maindec
    import controller_pkg::*;
(
    input  logic [OP_W-1:0] op,
    output main_ctrl_t      ctrl
);

    // Opcode to control-bundle table; unknown opcodes get the no-op word
    always_comb begin
        ctrl = MAIN_CTRL_NOP;
        case (op)
            //                       rw    rd    as    mw    mt    j     beq   bne
            OP_RTYPE: ctrl = main_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_FUNCT);
            OP_LW:    ctrl = main_ctrl(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALUOP_ADD);
            OP_SW:    ctrl = main_ctrl(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_ADD);
            OP_BEQ:   ctrl = main_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALUOP_SUB);
            OP_BNE:   ctrl = main_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_SUB);
            OP_ADDI:  ctrl = main_ctrl(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_ADD);
            OP_ANDI:  ctrl = main_ctrl(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_AND);
            OP_ORI:   ctrl = main_ctrl(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_OR);
            OP_SLTI:  ctrl = main_ctrl(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_SLT);
            OP_J:     ctrl = main_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ALUOP_ADD);
            default:  ctrl = MAIN_CTRL_NOP;
        endcase
    end

endmodule

// File: rtl/controller.sv
// -----------------------------------------------------------------------------
// controller
// Single-cycle MIPS-subset control unit. Purely combinational decode of
// op/funct/zero into datapath controls, with same-cycle outputs.
//   clk   : system clock (consumers sample controls on its rising edge)
//   reset : active-high; while high, regwrite/memwrite/pcsrc/jump are held 0
//           so the edge that ends a reset cycle commits nothing
//   bus   : controller_if.slave (op, funct, zero in; all controls out)
// -----------------------------------------------------------------------------
module controller
    import controller_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    controller_if.slave  bus
);

    main_ctrl_t  main_ctrl_w;
    alucontrol_t alucontrol_w;
    logic        funct_valid;
    logic        branch_taken;

    // The unit holds no state; clk is carried only so the block has the same
    // clocking port as its neighbours in the CPU top.
    logic unused_clk;
    assign unused_clk = clk;

    controller_maindec u_maindec (
        .op   (bus.op),
        .ctrl (main_ctrl_w)
    );

    controller_aludec u_aludec (
        .aluop       (main_ctrl_w.aluop),
        .funct       (bus.funct),
        .alucontrol  (alucontrol_w),
        .funct_valid (funct_valid)
    );

    assign branch_taken = (main_ctrl_w.branch_eq &  bus.zero)
                        | (main_ctrl_w.branch_ne & ~bus.zero);

    // Side-effecting controls are gated by reset; an unimplemented R-type
    // funct also suppresses the register write.
    assign bus.regwrite   = main_ctrl_w.regwrite & funct_valid & ~reset;
    assign bus.memwrite   = main_ctrl_w.memwrite & ~reset;
    assign bus.pcsrc      = branch_taken & ~reset;
    assign bus.jump       = main_ctrl_w.jump & ~reset;

    // Steering controls decode normally regardless of reset.
    assign bus.regdst     = main_ctrl_w.regdst;
    assign bus.alusrc     = main_ctrl_w.alusrc;
    assign bus.memtoreg   = main_ctrl_w.memtoreg;
    assign bus.alucontrol = alucontrol_w;

endmodule

// File: tb/tb_controller.sv
// -----------------------------------------------------------------------------
// tb_controller
// Directed bench for the control unit. Each task applies a small table of
// hand-computed vectors; expected words pack the outputs as
// {regwrite, regdst, alusrc, memwrite, memtoreg, pcsrc, jump, alucontrol[3:0]}.
// -----------------------------------------------------------------------------
module tb_controller;

    typedef struct packed {
        logic       rst;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic [6:0] exp_bits;
        logic [3:0] exp_alu;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    controller_if bus ();

    controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] observed();
        return {bus.regwrite, bus.regdst, bus.alusrc, bus.memwrite,
                bus.memtoreg, bus.pcsrc, bus.jump, bus.alucontrol};
    endfunction

    task automatic apply(input vec_t v);
        @(negedge clk);
        reset     = v.rst;
        bus.op    = v.op;
        bus.funct = v.funct;
        bus.zero  = v.zero;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vec_t v [3];
        logic [10:0] obs;
        // lw under reset: side effects off, steering still decoded
        v[0] = '{1'b1, 6'b100011, 6'b000000, 1'b0, 7'b0010100, 4'b0010};
        // R-type add under reset: regwrite off, regdst still 1
        v[1] = '{1'b1, 6'b000000, 6'b100000, 1'b0, 7'b0100000, 4'b0010};
        // sw under reset: memwrite off
        v[2] = '{1'b1, 6'b101011, 6'b000000, 1'b0, 7'b0010000, 4'b0010};
        for (int i = 0; i < 3; i++) begin
            apply(v[i]);
            obs = observed();
            checks++;
            if (obs !== {v[i].exp_bits, v[i].exp_alu}) begin
                $display("FAIL reset[%0d] got=%b exp=%b", i, obs, {v[i].exp_bits, v[i].exp_alu});
                failures++;
            end
        end
    endtask

    task automatic test_rtype();
        vec_t v [7];
        logic [10:0] obs;
        v[0] = '{1'b0, 6'b000000, 6'b100000, 1'b0, 7'b1100000, 4'b0010}; // add
        v[1] = '{1'b0, 6'b000000, 6'b100010, 1'b1, 7'b1100000, 4'b0110}; // sub, zero=1
        v[2] = '{1'b0, 6'b000000, 6'b100100, 1'b0, 7'b1100000, 4'b0000}; // and
        v[3] = '{1'b0, 6'b000000, 6'b100101, 1'b1, 7'b1100000, 4'b0001}; // or
        v[4] = '{1'b0, 6'b000000, 6'b100111, 1'b0, 7'b1100000, 4'b1100}; // nor
        v[5] = '{1'b0, 6'b000000, 6'b101010, 1'b0, 7'b1100000, 4'b0111}; // slt
        v[6] = '{1'b0, 6'b000000, 6'b111111, 1'b0, 7'b0100000, 4'b0010}; // unknown funct
        for (int i = 0; i < 7; i++) begin
            apply(v[i]);
            obs = observed();
            checks++;
            if (obs !== {v[i].exp_bits, v[i].exp_alu}) begin
                $display("FAIL rtype[%0d] got=%b exp=%b", i, obs, {v[i].exp_bits, v[i].exp_alu});
                failures++;
            end
        end
    endtask

    task automatic test_load_store();
        vec_t v [2];
        logic [10:0] obs;
        v[0] = '{1'b0, 6'b100011, 6'bxxxxxx, 1'b0, 7'b1010100, 4'b0010}; // lw, funct X
        v[1] = '{1'b0, 6'b101011, 6'bxxxxxx, 1'b1, 7'b0011000, 4'b0010}; // sw, funct X
        for (int i = 0; i < 2; i++) begin
            apply(v[i]);
            obs = observed();
            checks++;
            if ($isunknown(obs) || obs !== {v[i].exp_bits, v[i].exp_alu}) begin
                $display("FAIL ldst[%0d] got=%b exp=%b", i, obs, {v[i].exp_bits, v[i].exp_alu});
                failures++;
            end
        end
    endtask

    task automatic test_branch();
        vec_t v [4];
        logic [10:0] obs;
        v[0] = '{1'b0, 6'b000100, 6'b100000, 1'b0, 7'b0000000, 4'b0110}; // beq not taken
        v[1] = '{1'b0, 6'b000100, 6'b100000, 1'b1, 7'b0000010, 4'b0110}; // beq taken
        v[2] = '{1'b0, 6'b000101, 6'b100100, 1'b0, 7'b0000010, 4'b0110}; // bne taken
        v[3] = '{1'b0, 6'b000101, 6'b100100, 1'b1, 7'b0000000, 4'b0110}; // bne not taken
        for (int i = 0; i < 4; i++) begin
            apply(v[i]);
            obs = observed();
            checks++;
            if (obs !== {v[i].exp_bits, v[i].exp_alu}) begin
                $display("FAIL branch[%0d] got=%b exp=%b", i, obs, {v[i].exp_bits, v[i].exp_alu});
                failures++;
            end
        end
    endtask

    task automatic test_immediate();
        vec_t v [4];
        logic [10:0] obs;
        // funct carries R-type codes that must be ignored
        v[0] = '{1'b0, 6'b001000, 6'b100010, 1'b0, 7'b1010000, 4'b0010}; // addi
        v[1] = '{1'b0, 6'b001100, 6'b100101, 1'b1, 7'b1010000, 4'b0000}; // andi
        v[2] = '{1'b0, 6'b001101, 6'b100100, 1'b0, 7'b1010000, 4'b0001}; // ori
        v[3] = '{1'b0, 6'b001010, 6'b100000, 1'b1, 7'b1010000, 4'b0111}; // slti
        for (int i = 0; i < 4; i++) begin
            apply(v[i]);
            obs = observed();
            checks++;
            if (obs !== {v[i].exp_bits, v[i].exp_alu}) begin
                $display("FAIL imm[%0d] got=%b exp=%b", i, obs, {v[i].exp_bits, v[i].exp_alu});
                failures++;
            end
        end
    endtask

    task automatic test_jump_unknown();
        vec_t v [4];
        logic [10:0] obs;
        v[0] = '{1'b0, 6'b000010, 6'b101010, 1'b1, 7'b0000001, 4'b0010}; // j
        v[1] = '{1'b0, 6'b111111, 6'b100010, 1'b1, 7'b0000000, 4'b0010}; // unknown op
        v[2] = '{1'b0, 6'b000001, 6'b000000, 1'b0, 7'b0000000, 4'b0010}; // unknown op
        v[3] = '{1'b0, 6'b100100, 6'b100111, 1'b0, 7'b0000000, 4'b0010}; // unknown op
        for (int i = 0; i < 4; i++) begin
            apply(v[i]);
            obs = observed();
            checks++;
            if (obs !== {v[i].exp_bits, v[i].exp_alu}) begin
                $display("FAIL jmpunk[%0d] got=%b exp=%b", i, obs, {v[i].exp_bits, v[i].exp_alu});
                failures++;
            end
        end
    endtask

    task automatic test_reset_release();
        vec_t v [4];
        logic [10:0] obs;
        v[0] = '{1'b1, 6'b000100, 6'b000000, 1'b1, 7'b0000000, 4'b0110}; // beq taken, held
        v[1] = '{1'b0, 6'b000100, 6'b000000, 1'b1, 7'b0000010, 4'b0110}; // released
        v[2] = '{1'b1, 6'b000010, 6'b000000, 1'b0, 7'b0000000, 4'b0010}; // j held
        v[3] = '{1'b0, 6'b000010, 6'b000000, 1'b0, 7'b0000001, 4'b0010}; // released
        for (int i = 0; i < 4; i++) begin
            apply(v[i]);
            obs = observed();
            checks++;
            if (obs !== {v[i].exp_bits, v[i].exp_alu}) begin
                $display("FAIL rstrel[%0d] got=%b exp=%b", i, obs, {v[i].exp_bits, v[i].exp_alu});
                failures++;
            end
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        bus.op    = 6'b000000;
        bus.funct = 6'b000000;
        bus.zero  = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_rtype();
        test_load_store();
        test_branch();
        test_immediate();
        test_jump_unknown();
        test_reset_release();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
